jp_device: RTL and testbench
============================

JP_DEVICE -- requirements
Module: jp_device

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16'd1000, meaning consecutive clk_in cycles a button level must differ from its debounced state before the state updates (legal range 1..65535).
REQ-002 SHALL have port clk_in, input, 1, single system clock; all state on rising edge.
REQ-003 SHALL have port rst_n_in, input, 1, reset, asynchronous assert, active-low.
REQ-004 SHALL have port btn_in, input, 8, raw button levels, active-high (bit0 A, 1 B, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right), asynchronous to clk_in.
REQ-005 SHALL have port jp_latch_in, input, 1, console latch strobe, asynchronous to clk_in.
REQ-006 SHALL have port jp_clk_in, input, 1, console shift clock, asynchronous to clk_in.
REQ-007 SHALL have port jp_data_out, output, 1, serial button data, 1 = pressed, registered.
REQ-008 SHALL have port btn_state_out, output, 8, current debounced button state.
REQ-009 SHALL have port shift_cnt_out, output, 4, bits shifted since last load, saturating at 8.

Function
REQ-010 SHALL pass btn_in, jp_latch_in and jp_clk_in each through a 2-flop synchronizer before any use.
REQ-011 SHALL keep one 16-bit counter per button: cleared when synchronized level equals debounced bit, incremented otherwise; on reaching DEBOUNCE_CYCLES the debounced bit takes the synchronized level and the counter clears.
REQ-012 SHALL update a debounced bit exactly DEBOUNCE_CYCLES clocks after its synchronized level first differs, provided it differs on every one of those clocks; any glitch restarts the count.
REQ-013 SHALL implement a 2-state FSM: S_LOAD (synchronized latch high) and S_SHIFT (synchronized latch low); transition evaluated every clock from the synchronized latch level alone.
REQ-014 SHALL, in S_LOAD, load the 8-bit shift register from the debounced state every clock and clear shift_cnt_out to 0.
REQ-015 SHALL detect jp_clk rising edge as synchronized level high and its one-clock-delayed copy low.
REQ-016 SHALL, in S_SHIFT on a detected rising edge, shift the register right by one, insert 1 at bit7, and increment shift_cnt_out, saturating at 8.
REQ-017 SHALL drive jp_data_out from shift register bit0, so A appears after load, then B, Select, Start, Up, Down, Left, Right, then constant 1 after 8 or more shifts.
REQ-018 SHALL give latch priority: a clock edge coinciding with synchronized latch high causes load, not shift, and shift_cnt_out stays 0.
REQ-019 SHALL ignore jp_clk falling edges; falling latch edge leaves register contents unchanged.
REQ-020 SHALL show jp_data_out changes 3 clk_in cycles after a jp_latch_in or jp_clk_in input edge (2 sync + 1 register).
REQ-021 SHALL require, as an input constraint, jp_clk_in and jp_latch_in high and low phases of at least 3 clk_in periods; shorter pulses may be missed and need not be handled.
REQ-022 SHALL let debounced-state changes during S_LOAD appear on jp_data_out (bit0) the following clock; changes during S_SHIFT do not affect data until next load.

Reset
REQ-023 SHALL, while rst_n_in low, force synchronizers, edge-detect flop, debounce counters, btn_state_out, shift register and shift_cnt_out to 0 and FSM to S_SHIFT; jp_data_out = 0.
REQ-024 SHALL resume from reset values on the first rising clk_in after rst_n_in deasserts; a reset mid-shift discards the sequence, and the next latch restarts it.

Verification
REQ-025 SHALL cover reset: rst_n_in low with btn_in=8'hFF, latch high -> jp_data_out=0, btn_state_out=8'h00, shift_cnt_out=0.
REQ-026 SHALL cover full read: DEBOUNCE_CYCLES=4, btn_in=8'b1000_1001 held settled, latch pulse, 10 clk pulses -> serial 1,0,0,1,0,0,0,1,1,1; shift_cnt_out ends at 8.
REQ-027 SHALL cover debounce: DEBOUNCE_CYCLES=4, btn_in[0] toggles high 3 clocks then low -> btn_state_out[0] stays 0; held high -> becomes 1 exactly 4 clocks after synchronized rise.
REQ-028 SHALL cover latch priority: jp_clk_in and jp_latch_in rise same cycle with btn_in=8'h02 -> jp_data_out=0 (A), shift_cnt_out=0, after latch falls next clk gives 1.
REQ-029 SHALL cover transparent load: latch held high, btn_in[0] debounced 0->1 -> jp_data_out follows to 1 one clock after btn_state_out[0] changes.
REQ-030 SHALL cover mid-shift reset: reset after 3 shifts -> jp_data_out=0, shift_cnt_out=0; subsequent latch/read returns full correct sequence.

Source files
------------

// File: rtl/jp_device.sv
// Joypad serial emulator: synchronizes and debounces eight raw buttons and
// presents them on a latch/shift-clock serial port (A first, 1s after eight bits).
module jp_device #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd1000
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic [7:0] btn_in,
  input  logic       jp_latch_in,
  input  logic       jp_clk_in,
  output logic       jp_data_out,
  output logic [7:0] btn_state_out,
  output logic [3:0] shift_cnt_out
);

  typedef enum logic {S_SHIFT = 1'b0, S_LOAD = 1'b1} state_e;

  logic [7:0] btn_s1_q, btn_s2_q;
  logic       latch_s1_q;
  logic       jclk_s1_q, jclk_s2_q, jclk_d1_q;
  state_e     state_q, state_d;
  logic [7:0] shreg_q, shreg_d;
  logic [3:0] shift_cnt_q, shift_cnt_d;
  logic [7:0] btn_state_w;
  logic       jclk_rise;

  // The FSM state register doubles as the second synchronizer stage of the latch.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      btn_s1_q    <= 8'h00;
      btn_s2_q    <= 8'h00;
      latch_s1_q  <= 1'b0;
      state_q     <= S_SHIFT;
      jclk_s1_q   <= 1'b0;
      jclk_s2_q   <= 1'b0;
      jclk_d1_q   <= 1'b0;
      shreg_q     <= 8'h00;
      shift_cnt_q <= 4'd0;
    end else begin
      btn_s1_q    <= btn_in;
      btn_s2_q    <= btn_s1_q;
      latch_s1_q  <= jp_latch_in;
      state_q     <= state_d;
      jclk_s1_q   <= jp_clk_in;
      jclk_s2_q   <= jclk_s1_q;
      jclk_d1_q   <= jclk_s2_q;
      shreg_q     <= shreg_d;
      shift_cnt_q <= shift_cnt_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_deb
      logic [15:0] cnt_q, cnt_d;
      logic        deb_q, deb_d;

      // Any sample matching the debounced level restarts the qualification window.
      always_comb begin
        cnt_d = cnt_q;
        deb_d = deb_q;
        if (btn_s2_q[gi] == deb_q) begin
          cnt_d = 16'd0;
        end else if (cnt_q + 16'd1 == DEBOUNCE_CYCLES) begin
          deb_d = btn_s2_q[gi];
          cnt_d = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
          cnt_q <= 16'd0;
          deb_q <= 1'b0;
        end else begin
          cnt_q <= cnt_d;
          deb_q <= deb_d;
        end
      end

      assign btn_state_w[gi] = deb_q;
    end
  endgenerate

  assign jclk_rise = jclk_s2_q & ~jclk_d1_q;

  always_comb begin
    state_d     = latch_s1_q ? S_LOAD : S_SHIFT;
    shreg_d     = shreg_q;
    shift_cnt_d = shift_cnt_q;
    if (state_q == S_LOAD) begin
      shreg_d     = btn_state_w;
      shift_cnt_d = 4'd0;
    end else if (jclk_rise) begin
      shreg_d = {1'b1, shreg_q[7:1]};
      if (shift_cnt_q != 4'd8) begin
        shift_cnt_d = shift_cnt_q + 4'd1;
      end
    end
  end

  assign jp_data_out   = shreg_q[0];
  assign btn_state_out = btn_state_w;
  assign shift_cnt_out = shift_cnt_q;

endmodule

// File: tb/tb_jp_device.sv
// Self-checking bench for jp_device with a short debounce window; expected
// serial bits are queued when a read starts and popped as each bit is sampled.
module tb_jp_device;

  logic       clk_in      = 1'b0;
  logic       rst_n_in    = 1'b0;
  logic [7:0] btn_in      = 8'hFF;
  logic       jp_latch_in = 1'b1;
  logic       jp_clk_in   = 1'b0;
  logic       jp_data_out;
  logic [7:0] btn_state_out;
  logic [3:0] shift_cnt_out;

  int errors = 0;
  int checks = 0;
  bit exp_q[$];

  jp_device #(.DEBOUNCE_CYCLES(16'd4)) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .btn_in        (btn_in),
    .jp_latch_in   (jp_latch_in),
    .jp_clk_in     (jp_clk_in),
    .jp_data_out   (jp_data_out),
    .btn_state_out (btn_state_out),
    .shift_cnt_out (shift_cnt_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200us;
    $display("FAIL watchdog: sim time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic settle_buttons(input logic [7:0] b);
    btn_in = b;
    tick(12);
    checks++;
    if (btn_state_out !== b)
      begin errors++; $display("FAIL settle: btn_state_out=%h required %h", btn_state_out, b); end
  endtask

  // Latch, then sample the line before any pulse and after each of the pulses.
  task automatic read_seq(input logic [7:0] b, input int pulses);
    bit         exp;
    logic [3:0] expc;
    for (int i = 0; i <= pulses; i++) exp_q.push_back((i < 8) ? b[i] : 1'b1);
    jp_latch_in = 1'b1;
    tick(4);
    checks++;
    if (shift_cnt_out !== 4'd0)
      begin errors++; $display("FAIL load_cnt: shift_cnt_out=%0d required 0", shift_cnt_out); end
    jp_latch_in = 1'b0;
    tick(4);
    for (int i = 0; i <= pulses; i++) begin
      if (i > 0) begin
        jp_clk_in = 1'b1; tick(4);
        jp_clk_in = 1'b0; tick(4);
      end
      exp  = exp_q.pop_front();
      expc = (i > 8) ? 4'd8 : 4'(i);
      $display("read %h bit %0d: data=%b cnt=%0d", b, i, jp_data_out, shift_cnt_out);
      checks++;
      if (jp_data_out !== exp)
        begin errors++; $display("FAIL read_data[%0d]: data=%b required %b", i, jp_data_out, exp); end
      checks++;
      if (shift_cnt_out !== expc)
        begin errors++; $display("FAIL read_cnt[%0d]: cnt=%0d required %0d", i, shift_cnt_out, expc); end
    end
  endtask

  task automatic test_reset();
    tick(4);
    checks++;
    if (jp_data_out !== 1'b0)
      begin errors++; $display("FAIL reset_data: data=%b required 0", jp_data_out); end
    checks++;
    if (btn_state_out !== 8'h00)
      begin errors++; $display("FAIL reset_state: btn_state_out=%h required 00", btn_state_out); end
    checks++;
    if (shift_cnt_out !== 4'd0)
      begin errors++; $display("FAIL reset_cnt: cnt=%0d required 0", shift_cnt_out); end
    $display("reset: data=%b state=%h cnt=%0d", jp_data_out, btn_state_out, shift_cnt_out);
    jp_latch_in = 1'b0;
    rst_n_in    = 1'b1;
    tick(2);
  endtask

  task automatic test_full_read();
    settle_buttons(8'b1000_1001);
    read_seq(8'b1000_1001, 10);
    settle_buttons(8'h5A);
    read_seq(8'h5A, 9);
  endtask

  task automatic test_debounce();
    settle_buttons(8'h00);
    btn_in = 8'h01;
    tick(3);
    btn_in = 8'h00;
    tick(10);
    checks++;
    if (btn_state_out[0] !== 1'b0)
      begin errors++; $display("FAIL deb_glitch: state[0]=%b required 0", btn_state_out[0]); end
    btn_in = 8'h01;
    tick(5);
    checks++;
    if (btn_state_out[0] !== 1'b0)
      begin errors++; $display("FAIL deb_early: state[0]=%b required 0", btn_state_out[0]); end
    tick(1);
    checks++;
    if (btn_state_out[0] !== 1'b1)
      begin errors++; $display("FAIL deb_update: state[0]=%b required 1", btn_state_out[0]); end
    $display("debounce: state=%h", btn_state_out);
  endtask

  task automatic test_transparent_load();
    settle_buttons(8'h00);
    jp_latch_in = 1'b1;
    tick(4);
    checks++;
    if (jp_data_out !== 1'b0)
      begin errors++; $display("FAIL tload_pre: data=%b required 0", jp_data_out); end
    btn_in = 8'h01;
    tick(6);
    checks++;
    if (btn_state_out[0] !== 1'b1 || jp_data_out !== 1'b0)
      begin errors++; $display("FAIL tload_same: state0=%b data=%b required 1 0", btn_state_out[0], jp_data_out); end
    tick(1);
    checks++;
    if (jp_data_out !== 1'b1)
      begin errors++; $display("FAIL tload_follow: data=%b required 1", jp_data_out); end
    $display("transparent load: data=%b", jp_data_out);
    jp_latch_in = 1'b0;
    tick(4);
  endtask

  task automatic test_latch_priority();
    bit exp;
    settle_buttons(8'h02);
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    jp_latch_in = 1'b1;
    jp_clk_in   = 1'b1;
    tick(4);
    jp_latch_in = 1'b0;
    tick(4);
    exp = exp_q.pop_front();
    checks++;
    if (jp_data_out !== exp || shift_cnt_out !== 4'd0)
      begin errors++; $display("FAIL prio_load: data=%b cnt=%0d required %b 0", jp_data_out, shift_cnt_out, exp); end
    jp_clk_in = 1'b0; tick(4);
    jp_clk_in = 1'b1; tick(4);
    exp = exp_q.pop_front();
    checks++;
    if (jp_data_out !== exp || shift_cnt_out !== 4'd1)
      begin errors++; $display("FAIL prio_shift: data=%b cnt=%0d required %b 1", jp_data_out, shift_cnt_out, exp); end
    $display("latch priority: data=%b cnt=%0d", jp_data_out, shift_cnt_out);
    jp_clk_in = 1'b0;
    tick(4);
  endtask

  task automatic test_mid_shift_reset();
    settle_buttons(8'b1000_1001);
    jp_latch_in = 1'b1; tick(4);
    jp_latch_in = 1'b0; tick(4);
    for (int i = 0; i < 3; i++) begin
      jp_clk_in = 1'b1; tick(4);
      jp_clk_in = 1'b0; tick(4);
    end
    checks++;
    if (shift_cnt_out !== 4'd3 || jp_data_out !== 1'b1)
      begin errors++; $display("FAIL mid_pre: cnt=%0d data=%b required 3 1", shift_cnt_out, jp_data_out); end
    rst_n_in = 1'b0;
    tick(2);
    checks++;
    if (jp_data_out !== 1'b0 || shift_cnt_out !== 4'd0 || btn_state_out !== 8'h00)
      begin errors++; $display("FAIL mid_reset: data=%b cnt=%0d state=%h required 0 0 00", jp_data_out, shift_cnt_out, btn_state_out); end
    $display("mid-shift reset: data=%b cnt=%0d", jp_data_out, shift_cnt_out);
    rst_n_in = 1'b1;
    settle_buttons(8'b1000_1001);
    read_seq(8'b1000_1001, 10);
  endtask

  initial begin
    test_reset();
    test_full_read();
    test_debounce();
    test_transparent_load();
    test_latch_priority();
    test_mid_shift_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
